// File: rtl/flag_file_if.sv
// Flag-file bus: control-unit/ALU side (master) to the flag register file (slave).
interface flag_file_if #(
    parameter int unsigned NFLAGS     = 2,
    parameter int unsigned SHAD_DEPTH = 2
);
    localparam int unsigned CW = $clog2(SHAD_DEPTH + 1);

    logic [NFLAGS-1:0] FLG_CLR;
    logic [NFLAGS-1:0] FLG_SET;
    logic [NFLAGS-1:0] FLG_LD;
    logic [NFLAGS-1:0] FLG_IN;
    logic              I_SET;
    logic              I_CLR;
    logic              SHAD_SAVE;
    logic              SHAD_RESTORE;
    logic              ERR_CLR;

    logic [NFLAGS-1:0] FLAGS;
    logic              I_FLAG;
    logic [CW-1:0]     SHAD_CNT;
    logic              SHAD_OVF;
    logic              SHAD_UNF;

    modport master (
        output FLG_CLR, FLG_SET, FLG_LD, FLG_IN,
        output I_SET, I_CLR, SHAD_SAVE, SHAD_RESTORE, ERR_CLR,
        input  FLAGS, I_FLAG, SHAD_CNT, SHAD_OVF, SHAD_UNF
    );

    modport slave (
        input  FLG_CLR, FLG_SET, FLG_LD, FLG_IN,
        input  I_SET, I_CLR, SHAD_SAVE, SHAD_RESTORE, ERR_CLR,
        output FLAGS, I_FLAG, SHAD_CNT, SHAD_OVF, SHAD_UNF
    );
endinterface

// File: rtl/flag_file.sv
// Condition-flag register with interrupt enable and a LIFO shadow stack
// that saves {I, FLAGS} on interrupt entry and restores them on RETIE.
module flag_file #(
    parameter int unsigned NFLAGS     = 2,
    parameter int unsigned SHAD_DEPTH = 2
) (
    input logic        CLK,
    input logic        RST,
    flag_file_if.slave bus
);
    localparam int unsigned CW = $clog2(SHAD_DEPTH + 1);
    localparam int unsigned EW = NFLAGS + 1;
    localparam int unsigned AW = (SHAD_DEPTH > 1) ? $clog2(SHAD_DEPTH) : 1;

    logic [NFLAGS-1:0] flags_q, flags_d;
    logic              i_q, i_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [EW-1:0]     stack_q [SHAD_DEPTH];

    logic              push_c, pop_c, full_c, empty_c, push_we_c;
    logic [NFLAGS-1:0] flags_upd_c;
    logic              i_upd_c;
    logic [AW-1:0]     wr_idx_c, rd_idx_c;
    logic [EW-1:0]     rd_entry_c;

    // Decode stack mode and compute the next architectural state.
    always_comb begin
        push_c      = bus.SHAD_SAVE & ~bus.SHAD_RESTORE;
        pop_c       = bus.SHAD_RESTORE & ~bus.SHAD_SAVE;
        full_c      = (cnt_q == CW'(SHAD_DEPTH));
        empty_c     = (cnt_q == CW'(0));
        wr_idx_c    = AW'(cnt_q);
        rd_idx_c    = AW'(cnt_q - CW'(1));
        rd_entry_c  = stack_q[rd_idx_c];

        // Per bit: clear beats set beats load beats hold.
        flags_upd_c = (((flags_q & ~bus.FLG_LD) | (bus.FLG_IN & bus.FLG_LD))
                       | bus.FLG_SET) & ~bus.FLG_CLR;
        i_upd_c     = bus.I_CLR ? 1'b0 : (bus.I_SET ? 1'b1 : i_q);

        flags_d     = flags_upd_c;
        i_d         = i_upd_c;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q & ~bus.ERR_CLR;
        unf_d       = unf_q & ~bus.ERR_CLR;
        push_we_c   = 1'b0;

        if (push_c) begin
            i_d = 1'b0;
            if (!full_c) begin
                push_we_c = 1'b1;
                cnt_d     = cnt_q + CW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (pop_c) begin
            if (!empty_c) begin
                i_d     = rd_entry_c[NFLAGS];
                flags_d = rd_entry_c[NFLAGS-1:0];
                cnt_d   = cnt_q - CW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    // Architectural state registers; reset overrides any stack op.
    always_ff @(posedge CLK) begin
        if (RST) begin
            flags_q <= '0;
            i_q     <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Shadow-stack storage captures the pre-edge context; contents need no reset.
    always_ff @(posedge CLK) begin
        if (push_we_c && !RST) begin
            stack_q[wr_idx_c] <= {i_q, flags_q};
        end
    end

    assign bus.FLAGS    = flags_q;
    assign bus.I_FLAG   = i_q;
    assign bus.SHAD_CNT = cnt_q;
    assign bus.SHAD_OVF = ovf_q;
    assign bus.SHAD_UNF = unf_q;
endmodule

// File: tb/tb_flag_file.sv
// Randomised and directed bench for flag_file against a queue-based context model.
module tb_flag_file;
    localparam int unsigned NF    = 2;
    localparam int unsigned DEPTH = 2;

    logic CLK = 1'b0;
    logic RST;

    flag_file_if #(.NFLAGS(NF), .SHAD_DEPTH(DEPTH)) bus ();

    flag_file #(.NFLAGS(NF), .SHAD_DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference context: flags, I, a LIFO of saved contexts, sticky errors.
    logic [NF-1:0] m_flags;
    logic          m_i;
    logic [NF:0]   m_stack [$];
    logic          m_ovf;
    logic          m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic [NF-1:0] clr, input logic [NF-1:0] set,
                              input logic [NF-1:0] ld, input logic [NF-1:0] din,
                              input logic iset, input logic iclr, input logic save,
                              input logic rest, input logic eclr);
        logic [NF-1:0] nf;
        logic          ni;
        logic [NF:0]   e;
        if (rst) begin
            m_flags = '0; m_i = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            m_stack.delete();
            return;
        end
        for (int b = 0; b < NF; b++) begin
            if (clr[b])      nf[b] = 1'b0;
            else if (set[b]) nf[b] = 1'b1;
            else if (ld[b])  nf[b] = din[b];
            else             nf[b] = m_flags[b];
        end
        if (iclr)      ni = 1'b0;
        else if (iset) ni = 1'b1;
        else           ni = m_i;
        if (eclr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (save && !rest) begin
            ni = 1'b0;
            if (m_stack.size() < DEPTH) m_stack.push_back({m_i, m_flags});
            else                        m_ovf = 1'b1;
        end else if (rest && !save) begin
            if (m_stack.size() > 0) begin
                e  = m_stack.pop_back();
                ni = e[NF];
                nf = e[NF-1:0];
            end else begin
                m_unf = 1'b1;
            end
        end
        m_flags = nf;
        m_i     = ni;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".flags"}, 32'(bus.FLAGS), 32'(m_flags));
        check({tag, ".i"},     32'(bus.I_FLAG), 32'(m_i));
        check({tag, ".cnt"},   32'(bus.SHAD_CNT), 32'(m_stack.size()));
        check({tag, ".ovf"},   32'(bus.SHAD_OVF), 32'(m_ovf));
        check({tag, ".unf"},   32'(bus.SHAD_UNF), 32'(m_unf));
    endtask

    // Apply one cycle of inputs, clock it, then compare against the model.
    task automatic step(input string tag, input logic rst, input logic [NF-1:0] clr,
                        input logic [NF-1:0] set, input logic [NF-1:0] ld,
                        input logic [NF-1:0] din, input logic iset, input logic iclr,
                        input logic save, input logic rest, input logic eclr);
        RST              = rst;
        bus.FLG_CLR      = clr;
        bus.FLG_SET      = set;
        bus.FLG_LD       = ld;
        bus.FLG_IN       = din;
        bus.I_SET        = iset;
        bus.I_CLR        = iclr;
        bus.SHAD_SAVE    = save;
        bus.SHAD_RESTORE = rest;
        bus.ERR_CLR      = eclr;
        @(posedge CLK);
        #1;
        model_step(rst, clr, set, ld, din, iset, iclr, save, rest, eclr);
        check_model(tag);
    endtask

    initial begin
        logic [NF-1:0] r0, r1, r2, r3;
        r0 = NF'($urandom); r1 = NF'($urandom); r2 = NF'($urandom); r3 = NF'($urandom);
        m_flags = '0; m_i = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        #2;

        // Reset with random inputs, including stack strobes.
        step("rst", 1'b1, r0, r1, r2, r3, 1'($urandom), 1'($urandom), 1'b1, 1'($urandom), 1'($urandom));
        check("rst_flags", 32'(bus.FLAGS), 32'd0);
        check("rst_i",     32'(bus.I_FLAG), 32'd0);
        check("rst_cnt",   32'(bus.SHAD_CNT), 32'd0);
        check("rst_err",   32'({bus.SHAD_OVF, bus.SHAD_UNF}), 32'd0);

        // Per-bit priority: clear > set > load.
        step("prio",  1'b0, 2'b01, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("prio_flags", 32'(bus.FLAGS), 32'h2);
        step("ld",    1'b0, 2'b00, 2'b00, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ld_flags", 32'(bus.FLAGS), 32'h1);

        // Save captures pre-edge context; restore overrides same-cycle controls.
        step("pre",   1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("sv",    1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("sv_state", 32'({bus.I_FLAG, bus.FLAGS, bus.SHAD_CNT}), 32'({1'b0, 2'b00, 2'd1}));
        step("rs",    1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rs_state", 32'({bus.I_FLAG, bus.FLAGS, bus.SHAD_CNT}), 32'({1'b1, 2'b11, 2'd0}));

        // Nesting: inner context comes back first.
        step("ctxA",  1'b0, 2'b00, 2'b00, 2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("svA",   1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("ctxB",  1'b0, 2'b00, 2'b00, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("svB",   1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("body",  1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rsB",   1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rsB_state", 32'({bus.I_FLAG, bus.FLAGS}), 32'({1'b1, 2'b10}));
        step("rsA",   1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rsA_state", 32'({bus.I_FLAG, bus.FLAGS, bus.SHAD_CNT}), 32'({1'b1, 2'b01, 2'd0}));

        // Overflow keeps the stack intact; underflow leaves flags alone.
        step("c1",    1'b0, 2'b00, 2'b00, 2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("s1",    1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("c2",    1'b0, 2'b00, 2'b00, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("s2",    1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("c3",    1'b0, 2'b00, 2'b00, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("s3",    1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ovf_state", 32'({bus.SHAD_OVF, bus.I_FLAG, bus.SHAD_CNT}), 32'({1'b1, 1'b0, 2'd2}));
        step("r2",    1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("r2_state", 32'({bus.I_FLAG, bus.FLAGS}), 32'({1'b1, 2'b10}));
        step("r1",    1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("r1_state", 32'({bus.I_FLAG, bus.FLAGS}), 32'({1'b1, 2'b01}));
        step("r0",    1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("unf_state", 32'({bus.SHAD_UNF, bus.FLAGS, bus.SHAD_CNT}), 32'({1'b1, 2'b01, 2'd0}));
        step("eclr",  1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("eclr_err", 32'({bus.SHAD_OVF, bus.SHAD_UNF}), 32'd0);
        // Error set wins over a coincident clear.
        step("eset",  1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("eset_unf", 32'(bus.SHAD_UNF), 32'd1);

        // Collision and reset during a save.
        step("cs",    1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("col1",  1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("col1_state", 32'({bus.I_FLAG, bus.SHAD_CNT}), 32'({1'b1, 2'd1}));
        step("col2",  1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("col2_state", 32'({bus.I_FLAG, bus.SHAD_CNT}), 32'({1'b0, 2'd1}));
        step("prst",  1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rstsv", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rstsv_state", 32'({bus.I_FLAG, bus.FLAGS, bus.SHAD_CNT}), 32'({1'b0, 2'b00, 2'd0}));

        // Random traffic with frequent stack strobes and rare reset.
        for (int n = 0; n < 3000; n++) begin
            logic s, r, rs;
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 63) == 0);
            step("rnd", rs, NF'($urandom & $urandom), NF'($urandom & $urandom), NF'($urandom),
                 NF'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), s, r,
                 ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/flag_file.md
Name: flag_file

Overview:
- Parametrised successor to the RAT C/Z flag register.
- Holds NFLAGS condition flags and an interrupt-enable flag I.
- Per-flag set/clear/load controls come from the control unit.
- An interrupt shadow stack of SHAD_DEPTH entries saves flags on interrupt entry and restores them on RETIE, so nested interrupts are supported.
- Sits between the ALU (flag results) and the control unit / branch logic (flag consumers).

Parameters:
- NFLAGS, 2, number of condition flags; bit 0 = C, bit 1 = Z, higher bits are general-purpose.
- SHAD_DEPTH, 2, number of shadow-stack entries (>=1).
- CW, $clog2(SHAD_DEPTH+1), width of the stack-occupancy count (derived; do not override).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- FLG_CLR  in  NFLAGS  per-flag clear.
- FLG_SET  in  NFLAGS  per-flag set.
- FLG_LD  in  NFLAGS  per-flag load from FLG_IN.
- FLG_IN  in  NFLAGS  ALU flag results (bit 0 = C, bit 1 = Z).
- I_SET  in  1  enable interrupts (SEI).
- I_CLR  in  1  disable interrupts (CLI).
- SHAD_SAVE  in  1  interrupt entry: push {I, FLAGS}, clear I.
- SHAD_RESTORE  in  1  RETIE: pop {I, FLAGS}.
- ERR_CLR  in  1  clear sticky error bits.
- FLAGS  out  NFLAGS  current flags; FLAGS[0] = C_FLAG, FLAGS[1] = Z_FLAG.
- I_FLAG  out  1  interrupt enable.
- SHAD_CNT  out  CW  shadow-stack occupancy, 0..SHAD_DEPTH.
- SHAD_OVF  out  1  sticky: save attempted while stack full.
- SHAD_UNF  out  1  sticky: restore attempted while stack empty.

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high; it takes effect on a rising CLK edge.
- Reset: FLAGS=0, I_FLAG=0, SHAD_CNT=0, SHAD_OVF=0, SHAD_UNF=0. Stack contents are don't-care. RST overrides all other inputs, including an in-flight save or restore.
- All outputs are registered; an input effect is visible on the outputs after exactly one CLK edge.
- Per-flag update, each bit independently: FLG_CLR > FLG_SET > FLG_LD > hold. With NFLAGS=2 and no stack ops this is bit-identical to the legacy C/Z register; Z then has only LD in practice.
- I update: I_CLR > I_SET > hold.
- Stack op decode, one of four modes each cycle:
  - IDLE (neither strobe).
  - PUSH (SHAD_SAVE only).
  - POP (SHAD_RESTORE only).
  - COLLIDE (both asserted): no stack op, count unchanged, no error flagged; per-bit and I updates apply normally.
- PUSH, SHAD_CNT<SHAD_DEPTH:
  - entry[SHAD_CNT] <= {I_FLAG, FLAGS}, using pre-edge values, so same-cycle per-bit ops are not captured.
  - SHAD_CNT increments.
  - I_FLAG <= 0, overriding I_SET.
  - FLAGS take the per-bit update as normal.
- PUSH, SHAD_CNT==SHAD_DEPTH:
  - Stack and count unchanged; the push is dropped.
  - SHAD_OVF <= 1.
  - I_FLAG <= 0 still.
  - FLAGS take the per-bit update.
- POP, SHAD_CNT>0:
  - {I_FLAG, FLAGS} <= entry[SHAD_CNT-1].
  - Overrides all per-bit and I controls that cycle.
  - SHAD_CNT decrements.
- POP, SHAD_CNT==0:
  - Count stays 0.
  - SHAD_UNF <= 1.
  - FLAGS and I take the normal per-bit / I update.
- Error bits: sticky until ERR_CLR or RST. If ERR_CLR coincides with a new error event, the set wins.
- Count never wraps; it saturates at 0 and SHAD_DEPTH by the rules above.
- LIFO order: nested save/save/restore/restore returns the inner context first, then the outer.

Test Plan:
- Reset: drive all inputs random with RST=1 for one edge -> FLAGS=00, I_FLAG=0, SHAD_CNT=0, OVF=UNF=0.
- Priority: FLG_CLR=01, FLG_SET=11, FLG_LD=11, FLG_IN=00 -> FLAGS=10 (C cleared, Z set). Then LD only with FLG_IN=01 -> FLAGS=01.
- Save/restore:
  - I=1, FLAGS=11, SHAD_SAVE with FLG_LD=11, FLG_IN=00 -> next cycle FLAGS=00, I=0, CNT=1.
  - Then SHAD_RESTORE with FLG_SET=11 and I_SET -> FLAGS=11, I=1, CNT=0.
- Nesting, DEPTH=2:
  - Save context A (I=1, FLAGS=01), then set FLAGS=10 and I=1, then save context B, then set FLAGS=11.
  - Restore -> I=1, FLAGS=10.
  - Restore -> I=1, FLAGS=01, CNT=0.
- Overflow/underflow:
  - With DEPTH=2, a third save -> CNT stays 2, OVF=1, I=0, stack intact; two restores then return the correct entries.
  - A restore at CNT=0 -> UNF=1, FLAGS unchanged.
  - ERR_CLR -> both error bits 0.
- Collision/reset mid-op:
  - SAVE and RESTORE together at CNT=1 -> CNT=1, I follows I_SET/I_CLR.
  - RST together with SHAD_SAVE at CNT=1 -> CNT=0, I=0, FLAGS=00.
